// File: rtl/user_data_fifo_reader_if.sv
// user_data_fifo_reader_if: AXI-Stream beat bundle from the FIFO reader toward the RapidIO core.
interface user_data_fifo_reader_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;
    modport master(output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave(input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/user_data_fifo_reader.sv
// user_data_fifo_reader: drains framed entries from a 1-cycle-latency FIFO into an AXI-Stream
// master through a 2-entry skid buffer, with store-and-forward gating and framing checks.
module user_data_fifo_reader #(
    parameter bit STORE_FWD = 1'b1,
    parameter int CNT_W     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [74:0]             fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_ena,
    input  logic                    wr_pkt_done,
    user_data_fifo_reader_if.master m,
    output logic [CNT_W-1:0]        pkt_cnt,
    output logic                    err_pulse
);
    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;
    state_t           state;
    logic [73:0]      b0, b1;
    logic [73:0]      beat;
    logic [1:0]       buf_cnt, occ, slot;
    logic             inflight, err_sticky;
    logic             sof, eof, poison, fwd, pop, sticky_nxt, gate;
    logic [CNT_W-1:0] pkt_view;
    assign {sof, eof, poison} = fifo_dout[74:72];
    assign fwd        = inflight && (state == PKT || (state == IDLE && sof));
    assign err_pulse  = inflight && (state == IDLE ? !sof : (state == PKT && sof));
    // A stray sof inside a packet is kept as a continuation but marks the packet bad
    assign sticky_nxt = (state == IDLE ? 1'b0 : err_sticky) | poison | (state == PKT && sof);
    assign beat       = {fifo_dout[63:0], fifo_dout[71:64], eof, eof && sticky_nxt};
    assign pop        = m.tvalid && m.tready;
    assign occ        = buf_cnt + {1'b0, inflight};
    assign slot       = buf_cnt - {1'b0, pop};
    // An eof already on the FIFO output no longer counts as a readable packet
    assign pkt_view   = pkt_cnt - CNT_W'(inflight && eof);
    assign gate       = !STORE_FWD || pkt_view != '0;
    assign fifo_rd_ena = rst_n && !fifo_empty && gate && (occ < 2'd2 || (occ == 2'd2 && pop));
    assign m.tvalid   = buf_cnt != 2'd0;
    assign {m.tdata, m.tkeep, m.tlast, m.tuser} = b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            err_sticky <= 1'b0;
            buf_cnt    <= 2'd0;
            inflight   <= 1'b0;
            pkt_cnt    <= '0;
            b0         <= '0;
            b1         <= '0;
        end else begin
            inflight <= fifo_rd_ena;
            buf_cnt  <= buf_cnt + 2'(fwd) - 2'(pop);
            pkt_cnt  <= pkt_cnt + CNT_W'(wr_pkt_done) - CNT_W'(inflight && eof);
            if (pop) b0 <= b1;
            if (fwd && slot == 2'd0) b0 <= beat;
            if (fwd && slot == 2'd1) b1 <= beat;
            if (fwd) err_sticky <= sticky_nxt;
            if (inflight) state <= eof ? IDLE : (state == IDLE ? (sof ? PKT : DROP) : state);
        end
    end
endmodule

// File: tb/tb_user_data_fifo_reader.sv
// tb_user_data_fifo_reader: scoreboard bench with a standard-mode FIFO model feeding the reader.
module tb_user_data_fifo_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [74:0] fifo_dout = '0;
    logic        fifo_empty, fifo_rd_ena, err_pulse;
    logic        wr_pkt_done = 1'b0;
    logic [9:0]  pkt_cnt;
    user_data_fifo_reader_if axis();

    user_data_fifo_reader #(.STORE_FWD(1'b1), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_ena(fifo_rd_ena), .wr_pkt_done(wr_pkt_done), .m(axis),
        .pkt_cnt(pkt_cnt), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    logic [74:0] mem [1024];
    int          wr_n = 0, rd_n = 0;
    assign fifo_empty = (wr_n == rd_n);

    // FIFO model: 1-cycle read latency, flushed by the shared reset
    always @(posedge clk) begin
        if (!rst_n) rd_n <= wr_n;
        else if (fifo_rd_ena && wr_n != rd_n) begin
            fifo_dout <= mem[rd_n % 1024];
            rd_n      <= rd_n + 1;
        end
    end

    logic [73:0] exp_q[$];
    int          beat_cyc[$];
    logic [73:0] got, want;
    int checks = 0, fails = 0, cyc = 0, rd_mark = -1, rd_seen = 0, errs = 0, e0;
    bit occ_bad = 0, empty_bad = 0, gate_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples mid-cycle; a beat with tvalid && tready here is taken at the next edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_ena) begin
                rd_seen++;
                if (rd_mark < 0) rd_mark = cyc;
            end
            if (fifo_rd_ena && fifo_empty) empty_bad = 1;
            if (fifo_rd_ena && pkt_cnt == 0) gate_bad = 1;
            if (int'(dut.buf_cnt) + int'(dut.inflight) > 2) occ_bad = 1;
            if (err_pulse) errs++;
            if (axis.tvalid && axis.tready) begin
                beat_cyc.push_back(cyc);
                got = {axis.tdata, axis.tkeep, axis.tlast, axis.tuser};
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got %h, required no beat", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        fails++;
                        $display("FAIL beat: got %h, required %h", got, want);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wr(input logic [74:0] e, input bit done);
        @(negedge clk);
        mem[wr_n % 1024] = e;
        wr_n++;
        wr_pkt_done = done;
        @(posedge clk);
        #1 wr_pkt_done = 1'b0;
    endtask

    // One entry of packet id: sof on beat 0 if head, eof on the last beat, poison on beat pb
    task automatic beat(input int id, input int i, input int n, input int pb, input bit head);
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        d = {32'(id), 32'(i)};
        l = (i == n - 1);
        k = l ? 8'h0F : 8'hFF;
        if (head) exp_q.push_back({d, k, l, l && pb >= 0});
        wr({head && i == 0, l, i == pb, k, d}, l);
    endtask

    task automatic pkt(input int id, input int n, input int pb, input bit head);
        for (int i = 0; i < n; i++) beat(id, i, n, pb, head);
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk);
        #1 axis.tready = v;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(name, 64'(exp_q.size()), 0);
    endtask

    initial begin
        axis.tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_ena", 64'(fifo_rd_ena), 0);
        chk("rst_tvalid", 64'(axis.tvalid), 0);
        chk("rst_tlast", 64'(axis.tlast), 0);
        chk("rst_tuser", 64'(axis.tuser), 0);
        chk("rst_tdata", axis.tdata, 0);
        chk("rst_tkeep", 64'(axis.tkeep), 0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 0);
        chk("rst_err_pulse", 64'(err_pulse), 0);
        @(negedge clk) rst_n = 1'b1;

        set_ready(1);
        rd_mark = -1;
        beat_cyc.delete();
        pkt(1, 4, -1, 1);
        drain("t1_drain");
        chk("t1_beats", 64'(beat_cyc.size()), 4);
        if (beat_cyc.size() == 4) begin
            chk("t1_latency", 64'(beat_cyc[0] - rd_mark), 2);
            chk("t1_contig", 64'(beat_cyc[3] - beat_cyc[0]), 3);
        end
        chk("t1_pkt_cnt", 64'(pkt_cnt), 0);

        rd_seen = 0;
        for (int i = 0; i < 3; i++) beat(2, i, 4, -1, 1);
        repeat (100) @(negedge clk);
        chk("t2_no_read", 64'(rd_seen), 0);
        beat(2, 3, 4, -1, 1);
        drain("t2_drain");

        set_ready(0);
        pkt(3, 8, -1, 1);
        pkt(4, 8, -1, 1);
        repeat (5) @(negedge clk);
        chk("t3_pkt_cnt", 64'(pkt_cnt), 2);
        beat_cyc.delete();
        set_ready(1);
        drain("t3_drain");
        chk("t3_beats", 64'(beat_cyc.size()), 16);
        if (beat_cyc.size() == 16) chk("t3_no_gap", 64'(beat_cyc[15] - beat_cyc[0]), 15);

        fork
            for (int p = 0; p < 25; p++) pkt(10 + p, 8, (p % 5 == 0) ? 2 : -1, 1);
            repeat (600) begin
                @(posedge clk);
                #1 axis.tready = 1'($urandom_range(0, 1));
            end
        join
        set_ready(1);
        drain("t4_drain");
        chk("t4_pkt_cnt", 64'(pkt_cnt), 0);

        e0 = errs;
        pkt(40, 2, -1, 0);
        pkt(41, 3, -1, 1);
        drain("t5_drain");
        chk("t5_err_pulses", 64'(errs - e0), 1);
        chk("t5_pkt_cnt", 64'(pkt_cnt), 0);

        pkt(50, 4, 1, 1);
        drain("t6_drain");

        set_ready(0);
        pkt(60, 4, -1, 1);
        repeat (6) @(negedge clk);
        chk("t7_tvalid_before", 64'(axis.tvalid), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_tvalid_rst", 64'(axis.tvalid), 0);
        chk("t7_pkt_cnt_rst", 64'(pkt_cnt), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e0 = errs;
        set_ready(1);
        pkt(61, 3, -1, 1);
        drain("t7_drain");
        chk("t7_err_pulses", 64'(errs - e0), 0);
        chk("t7_pkt_cnt", 64'(pkt_cnt), 0);

        chk("occupancy_le_2", 64'(occ_bad), 0);
        chk("rd_when_empty", 64'(empty_bad), 0);
        chk("rd_without_pkt", 64'(gate_bad), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
